// File: rtl/vga_timing.sv
// 640x480 VGA raster source: free-running pixel/line counters, coordinate decode
// for the renderers, and one output register stage aligning blanked rgb with syncs.
module vga_timing #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33
) (
   input  logic       clk,
   input  logic       reset_n,
   output logic [9:0] col,
   output logic [9:0] row,
   output logic       valid,
   output logic       frame_start,
   input  logic [5:0] rgb_in,
   output logic [5:0] rgb,
   output logic       hsync,
   output logic       vsync
);

   localparam int unsigned CW       = 10;
   localparam int unsigned RGB_W    = 6;
   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START = H_ACTIVE + H_FP;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_ACTIVE + V_FP;
   localparam int unsigned VS_END   = VS_START + V_SYNC;

   logic [CW-1:0]    h_cnt_q, h_cnt_d;
   logic [CW-1:0]    v_cnt_q, v_cnt_d;
   logic             h_wrap, v_wrap;
   logic             hs0, vs0;
   logic [RGB_W-1:0] rgb_q, rgb_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;

   // Raster counters: v advances only on the h wrap, both return to 0 together.
   always_comb begin
      h_wrap  = (h_cnt_q == CW'(H_TOTAL - 1));
      v_wrap  = (v_cnt_q == CW'(V_TOTAL - 1));
      h_cnt_d = h_wrap ? '0 : h_cnt_q + CW'(1);
      v_cnt_d = v_cnt_q;
      if (h_wrap) begin
         v_cnt_d = v_wrap ? '0 : v_cnt_q + CW'(1);
      end
   end

   // Decodes compared at 32 bits so a sync end of exactly 1024 cannot alias to 0.
   always_comb begin
      valid       = (32'(h_cnt_q) < H_ACTIVE) && (32'(v_cnt_q) < V_ACTIVE);
      frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
      hs0         = !((32'(h_cnt_q) >= HS_START) && (32'(h_cnt_q) < HS_END));
      vs0         = !((32'(v_cnt_q) >= VS_START) && (32'(v_cnt_q) < VS_END));
      rgb_d       = valid ? rgb_in : '0;
      hsync_d     = hs0;
      vsync_d     = vs0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         rgb_q   <= '0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         rgb_q   <= rgb_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
      end
   end

   assign col   = h_cnt_q;
   assign row   = v_cnt_q;
   assign rgb   = rgb_q;
   assign hsync = hsync_q;
   assign vsync = vsync_q;

endmodule
